// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage RV32M multiply/divide unit:
// funct3 codes, FSM encoding, iteration count and special-case results.
package muldiv_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned ITERATIONS = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [DATA_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [DATA_W-1:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [DATA_W-1:0] OVF_REM   = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Two's-complement negate when neg is set.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? DATA_W'(~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// One restoring-division step: shifts the next dividend bit into the
// partial remainder and produces one quotient bit.
module muldiv_div_iter
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] div_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_i < div_i always holds, so the shifted value fits in DATA_W+1 bits.
  always_comb begin
    shifted = {rem_i, quot_i[DATA_W-1]};
    diff    = shifted - {1'b0, div_i};
    if (!diff[DATA_W]) begin
      rem_o  = diff[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b1};
    end else begin
      rem_o  = shifted[DATA_W-1:0];
      quot_o = {quot_i[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; divide stays iterative.
module ex_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            stall_o,
  output logic [XLEN-1:0] result_o
);
  import muldiv_pkg::*;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [2*DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]     bmag_q, bmag_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  neg_q, neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  div0_q, div0_d;
  logic                  ovf_q, ovf_d;

  logic                  a_sgn, b_sgn, a_neg, b_neg;
  logic [DATA_W-1:0]     a_mag, b_mag;
  logic [DATA_W-1:0]     rem_nxt, quot_nxt;
  logic [2*DATA_W-1:0]   mul_sum, mul_prod;
  logic [DATA_W-1:0]     mul_res, div_res, div_spec_res;
  logic                  is_rem, last_iter;

  // Operand signedness and magnitudes for the request on the inputs.
  always_comb begin
    a_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
            (op_i == OP_DIV) || (op_i == OP_REM);
    b_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) ||
            (op_i == OP_DIV) || (op_i == OP_REM);
    a_neg = a_sgn & rs1_i[DATA_W-1];
    b_neg = b_sgn & rs2_i[DATA_W-1];
    a_mag = cond_neg(rs1_i, a_neg);
    b_mag = cond_neg(rs2_i, b_neg);
  end

  muldiv_div_iter u_div_iter (
    .rem_i  (acc_q[2*DATA_W-1:DATA_W]),
    .quot_i (acc_q[DATA_W-1:0]),
    .div_i  (bmag_q),
    .rem_o  (rem_nxt),
    .quot_o (quot_nxt)
  );

  // Datapath results of the current cycle.
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    mul_sum = sh_q * {{DATA_W{1'b0}}, bmag_q};
`else
    mul_sum = bmag_q[0] ? acc_q + sh_q : acc_q;
`endif
    mul_prod = neg_q ? (2*DATA_W)'(~mul_sum + (2*DATA_W)'(1)) : mul_sum;
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: mul_res = mul_prod[2*DATA_W-1:DATA_W];
      default:                      mul_res = mul_prod[DATA_W-1:0];
    endcase
    is_rem    = (op_q == OP_REM) || (op_q == OP_REMU);
    div_res   = is_rem ? cond_neg(rem_nxt, neg_rem_q) : cond_neg(quot_nxt, neg_q);
    if (div0_q) begin
      div_spec_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? DIV0_QUOT
                                                             : cond_neg(acc_q[DATA_W-1:0], neg_rem_q);
    end else begin
      div_spec_res = is_rem ? OVF_REM : OVF_QUOT;
    end
    last_iter = (cnt_q == CNT_W'(ITERATIONS - 1));
  end

  // Next-state and register updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    sh_d      = sh_q;
    bmag_d    = bmag_q;
    result_d  = result_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          op_d      = op_i;
          cnt_d     = '0;
          bmag_d    = b_mag;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (rs2_i == '0);
          ovf_d     = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                      (rs1_i == OVF_QUOT) && (rs2_i == DIV0_QUOT);
          if (op_i[2]) begin
            acc_d   = {{DATA_W{1'b0}}, a_mag};
            state_d = S_DIV;
          end else begin
            acc_d   = '0;
            sh_d    = {{DATA_W{1'b0}}, a_mag};
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
          result_d = mul_res;
          state_d  = S_DONE;
`else
          acc_d  = mul_sum;
          sh_d   = {sh_q[2*DATA_W-2:0], 1'b0};
          bmag_d = {1'b0, bmag_q[DATA_W-1:1]};
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_d = mul_res;
            state_d  = S_DONE;
          end
`endif
        end
      end
      S_DIV: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (div0_q || ovf_q) begin
          result_d = div_spec_res;
          state_d  = S_DONE;
        end else begin
          acc_d = {rem_nxt, quot_nxt};
          cnt_d = cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_d = div_res;
            state_d  = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      sh_q      <= '0;
      bmag_q    <= '0;
      result_q  <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      sh_q      <= sh_d;
      bmag_q    <= bmag_d;
      result_q  <= result_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy_o   = (state_q == S_MUL) || (state_q == S_DIV);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  // Stall is forced low while reset is asserted.
  assign stall_o  = rst_n & ((start_i & (state_q == S_IDLE) & ~flush_i) | busy_o);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vectors with literal results, an arithmetic
// reference model and a per-cycle output checker driven by the timing rules.
module tb_ex_muldiv;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int NO_ABORT = 1 << 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, done_o, stall_o;
  logic [31:0] result_o;

  ex_muldiv #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .stall_o  (stall_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Current transaction as seen by the checker (written only by the driver).
  int          t_acc = -1000;
  int          t_lat = 0;
  int          t_abort = NO_ABORT;
  logic [31:0] t_res = '0;
  logic [31:0] prev_lit = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:     begin p = sa * sb; return p[31:0];  end
      MULH:    begin p = sa * sb; return p[63:32]; end
      MULHSU:  begin p = sa * ub; return p[63:32]; end
      MULHU:   begin p = ua * ub; return p[63:32]; end
      DIV:     return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      DIVU:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      REM:     return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 0) return 2;
      if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 33;
`endif
  endfunction

  // Per-cycle checker: expected outputs follow from the accept cycle and latency.
  logic [31:0] last_res = '0;
  logic        busy_e, done_e, idle_e, stall_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_stall", 32'(stall_o), 32'd0);
      check("rst_result", result_o, 32'd0);
      last_res = '0;
    end else begin
      busy_e  = (cyc > t_acc) && (cyc < t_acc + t_lat) && (cyc <= t_abort);
      done_e  = (cyc == t_acc + t_lat) && (t_abort == NO_ABORT);
      idle_e  = !(busy_e || done_e);
      stall_e = busy_e || (start_i && idle_e && !flush_i);
      check("cyc_busy", 32'(busy_o), 32'(busy_e));
      check("cyc_done", 32'(done_o), 32'(done_e));
      check("cyc_stall", 32'(stall_o), 32'(stall_e));
      check("cyc_result", result_o, done_e ? t_res : last_res);
      if (done_e) last_res = t_res;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly the accept cycle; returns one cycle later.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    step();
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    t_acc   = cyc;
    t_lat   = exp_lat(op, a, b);
    t_res   = model(op, a, b);
    t_abort = NO_ABORT;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
    int n;
    bit seen;
    check({name, "_model"}, model(op, a, b), lit);
    issue(op, a, b);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: no done_o within 40 cycles (cycle %0d)", name, cyc);
    end else begin
      check({name, "_latency"}, 32'(n), 32'(exp_lat(op, a, b)));
      check({name, "_result"}, result_o, lit);
    end
    prev_lit = lit;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"mul_7x-3",      MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"mulh_m1",       MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{"mulhsu_m1",     MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{"mulhu_m1",      MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[4]  = '{"div_-7/2",      DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[5]  = '{"rem_-7/2",      REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[6]  = '{"divu_100/7",    DIVU,   32'd100,       32'd7,         32'd14};
    vecs[7]  = '{"remu_100/7",    REMU,   32'd100,       32'd7,         32'd2};
    vecs[8]  = '{"divu_5/0",      DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{"rem_5/0",       REM,    32'd5,         32'd0,         32'd5};
    vecs[10] = '{"div_ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{"rem_ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{"mulh_minsq",    MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[13] = '{"div_min/1",     DIV,    32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
    vecs[14] = '{"rem_7/-2",      REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[15] = '{"remu_max/16",   REMU,   32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush in idle blocks acceptance.
    step();
    start_i = 1'b1;
    flush_i = 1'b1;
    op_i    = MUL;
    step();
    start_i = 1'b0;
    flush_i = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 32'(busy_o), 32'd0);

    // Flush in cycle 10 of a divide, then a fresh start in cycle 12.
    issue(DIVU, 32'd1000, 32'd3);
    repeat (9) step();
    flush_i = 1'b1;
    t_abort = cyc;
    step();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);
    check("flush_result", result_o, prev_lit);
    run_op("after_flush", REMU, 32'd100, 32'd7, 32'd2);

    // Reset in cycle 15 of a multiply, with start_i high during reset.
    issue(MUL, 32'h0000_0007, 32'hFFFF_FFFD);
    repeat (14) step();
    rst_n   = 1'b0;
    start_i = 1'b1;
    t_abort = cyc;
    @(negedge clk);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    step();
    rst_n   = 1'b1;
    start_i = 1'b0;

    // start_i held through DONE: ignored there, accepted in the next idle cycle.
    step();
    start_i = 1'b1;
    op_i    = DIVU;
    rs1_i   = 32'd5;
    rs2_i   = 32'd0;
    t_acc   = cyc;
    t_lat   = 2;
    t_res   = model(DIVU, 32'd5, 32'd0);
    t_abort = NO_ABORT;
    step();
    step();
    op_i = REM;
    @(negedge clk);
    check("held_done1", 32'(done_o), 32'd1);
    check("held_stall_in_done", 32'(stall_o), 32'd0);
    check("held_result1", result_o, 32'hFFFF_FFFF);
    step();
    t_acc = cyc;
    t_lat = 2;
    t_res = model(REM, 32'd5, 32'd0);
    @(negedge clk);
    check("held_accept_stall", 32'(stall_o), 32'd1);
    step();
    step();
    start_i = 1'b0;
    @(negedge clk);
    check("held_done2", 32'(done_o), 32'd1);
    check("held_result2", result_o, 32'd5);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the execute stage, consuming the operand values delivered by the ID/EX pipeline register. It accepts one operation per `start_i` pulse, holds the front of the pipeline via `stall_o` while it computes, and presents a 32-bit result with a one-cycle `done_o` pulse. The EX/MEM register captures the result in the cycle `done_o` is high.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `clk  input  1`: clock.
- `rst_n  input  1`: reset, asynchronous, active-low.
- `start_i  input  1`: request a new operation. Sampled only in IDLE.
- `op_i  input  3`: RV32M funct3.
  - Multiply: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - Divide: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_i  input  32`: operand A (multiplicand/dividend), from ID/EX `rdata1`.
- `rs2_i  input  32`: operand B (multiplier/divisor), from ID/EX `rdata2`.
- `flush_i  input  1`: abort the operation in flight (branch/exception flush).
- `busy_o  output  1`: high in MUL and DIV states.
- `done_o  output  1`: one-cycle pulse; `result_o` is valid during it.
- `stall_o  output  1`: combinational.
  - (`start_i` & IDLE & !`flush_i`) | `busy_o`.
  - Holds IF/ID and ID/EX.
- `result_o  output  32`: result. Holds its value until the next accepted start.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - `start_i` & !`flush_i` latches `op_i`, `rs1_i` and `rs2_i`, clears the iteration counter (6 bits), and moves to MUL (`op_i[2]`=0) or DIV (`op_i[2]`=1).
  - `start_i` in any other state is ignored.
- MUL, iterative:
  - Shift-add over 64-bit magnitudes, one multiplier bit per cycle.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - Operate on absolute values; negate the 64-bit product when the operand signs differ.
  - MUL returns product[31:0]; the other ops return product[63:32].
- DIV, iterative:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Signed ops: the quotient is negative when the operand signs differ; the remainder takes the sign of the dividend.
- Special cases, detected on entry to DIV, skip the iterations and go to DONE after one cycle:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- After 32 iterations the state moves to DONE. `result_o` is written on that same edge.
- DONE: `done_o`=1 and `stall_o`=0 for exactly one cycle, then the state returns to IDLE.
- `flush_i`:
  - In MUL/DIV: next state is IDLE, no `done_o`, `result_o` unchanged.
  - In DONE: `done_o` still pulses. Discarding it is the downstream's job.
  - In IDLE: blocks acceptance of `start_i`.
- Reset, at any time including mid-operation: state IDLE, counter 0, `result_o`=0, `done_o`=0, `busy_o`=0. `stall_o` = 0 while reset is asserted.

## Timing
- Cycle 0 is the cycle in which `start_i` is accepted.
- Iterative operations: `busy_o` is high in cycles 1–32 and `done_o` is high in cycle 33. Next acceptance is possible in cycle 34.
- Special-case division: `busy_o` is high in cycle 1 and `done_o` in cycle 2.
- `stall_o`: high from cycle 0 through the last busy cycle, low in the DONE cycle.
- Back-to-back operations: a `start_i` held high through DONE is accepted in the following IDLE cycle.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - The MUL state performs the whole 64-bit signed/unsigned product in one cycle.
  - Multiply timing matches the special-case division path: `done_o` in cycle 2.
- Undefined: 32-cycle shift-add multiply.
- Division is always iterative.

## Structure
- `muldiv_pkg` holds:
  - funct3 localparams (`OP_MUL` … `OP_REMU`)
  - the state enum encoding
  - `ITERATIONS` = 32
  - the divide-by-zero and overflow result constants
- Sub-module `muldiv_div_iter`: one restoring-division step. Inputs: remainder, quotient and divisor; outputs: next remainder and next quotient. It is instantiated once and stepped by the FSM.

## Test plan
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → `result_o`=0xFFFFFFEB, `done_o` in cycle 33 (cycle 2 with `MULDIV_FAST_MUL_EN`).
- MULH / MULHSU / MULHU, operands 0xFFFFFFFF, 0xFFFFFFFF → 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- Special cases, each with `done_o` in cycle 2:
  - DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0.
- `flush_i` in cycle 10 of a DIV → IDLE in cycle 11, no `done_o`, `result_o` unchanged; a new start in cycle 12 completes normally.
- `rst_n` low in cycle 15 of a MUL → all outputs 0 immediately. After release, `start_i` in DONE is ignored and `start_i` held through DONE is accepted in the following IDLE cycle.
